pixel_write_arbiter: RTL
========================

Name: pixel_write_arbiter

Overview:
- Shares the frame-buffer write master between the line rasterizer and the arc rasterizer. Both engines are sequenced by the core control unit.
- Accepts one pixel at a time from either engine using valid/ready, with round-robin on contention.
- Clips pixels outside the frame and converts (x,y) to a byte address.
- Issues a single-beat Avalon-MM write that honours waitrequest, with a timeout that sets a sticky error.

Parameters:
- X_W, 10, pixel x coordinate width
- Y_W, 10, pixel y coordinate width
- FB_WIDTH, 640, frame width in pixels
- FB_HEIGHT, 480, frame height in pixels
- FB_BASE, 0, frame-buffer byte base address
- ADDR_W, 32, Avalon address width
- TIMEOUT, 255, maximum waitrequest cycles before abort
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  system clock
- nreset  in  1  synchronous, active-low reset
- line_valid  in  1  line engine has a pixel
- line_x / line_y / line_color  in  X_W / Y_W / 24  line pixel
- line_ready  out  1  line pixel accepted this cycle
- arc_valid  in  1  arc engine has a pixel
- arc_x / arc_y / arc_color  in  X_W / Y_W / 24  arc pixel
- arc_ready  out  1  arc pixel accepted this cycle
- avm_write  out  1  Avalon write request
- avm_address  out  ADDR_W  byte address
- avm_writedata  out  32  {8'h00, color}
- avm_waitrequest  in  1  slave stall
- clr_stats  in  1  clear counters and bus_err
- busy  out  1  state != IDLE
- bus_err  out  1  sticky write-timeout flag
- pix_written  out  CNT_W  completed writes, saturating
- pix_clipped  out  CNT_W  dropped out-of-bounds pixels, saturating

Behaviour:
- Reset:
  - Sampled on a clk edge with nreset=0.
  - State=IDLE; avm_write=0; avm_address=0; avm_writedata=0.
  - Counters=0; bus_err=0; last_grant=ARC, so the line engine wins the first tie.
  - Reset during WRITE abandons the transaction; avm_write is 0 after that edge.
- Handshake:
  - A transfer occurs in a cycle where valid && ready.
  - line_ready and arc_ready are combinational and asserted only in IDLE, and only for the winner.
  - A requester holds valid and its pixel stable until ready.
  - ready is never asserted to a requester whose valid is low.
- Arbitration in IDLE:
  - One valid only: that requester wins.
  - Both valid: the requester other than last_grant wins.
  - last_grant updates on every transfer, clipped or not.
- Clipping:
  - If x >= FB_WIDTH or y >= FB_HEIGHT, the pixel is still accepted (ready=1).
  - pix_clipped increments, no bus write is issued, and state stays IDLE.
- In-bounds transfer:
  - Register avm_address = FB_BASE + ((y*FB_WIDTH + x) << 2), computed modulo 2^ADDR_W.
  - Register avm_writedata = {8'h00, color}.
  - Go to WRITE; avm_write=1 from the next cycle.
- WRITE state:
  - avm_write, avm_address and avm_writedata are held constant while avm_waitrequest=1.
  - A wait counter increments each stalled cycle.
  - First edge with avm_waitrequest=0: the write completes, pix_written increments, and state returns to IDLE with avm_write=0.
  - Write completes at the earliest 1 cycle after acceptance. Peak throughput is 1 pixel per 2 cycles.
- Timeout:
  - If the wait counter reaches TIMEOUT while waitrequest is still 1, the write is abandoned.
  - bus_err is set; state goes to IDLE with avm_write=0; pix_written does not increment.
  - The wait counter clears on entry to WRITE.
- Counters:
  - Saturate at all-ones.
  - clr_stats=1 clears pix_written, pix_clipped and bus_err at the clock edge; clear wins over a simultaneous increment or error set.
  - clr_stats does not affect the state machine or an in-flight write.
- Other:
  - busy=1 exactly when state=WRITE.
  - No pixel is accepted during WRITE.

Test Plan:
- Line pixel x=3, y=2, color 24'hFF0000 with waitrequest=0 → line_ready pulses 1 cycle; next cycle avm_write=1, avm_address=5132, avm_writedata=32'h00FF0000; pix_written=1; busy low after 1 cycle.
- line_valid and arc_valid held together after reset, 4 pixels each → grant order L,A,L,A,L,A,L,A; exactly one ready per transfer.
- Arc pixel x=640, y=0, then x=0, y=480 → both accepted; no avm_write; pix_clipped=2; state stays IDLE.
- waitrequest high for 5 cycles on a write → avm_write, address and data stable for 6 cycles; the new pixel is not readied until completion; pix_written=1.
- waitrequest stuck high with TIMEOUT=255 → avm_write drops after 255 stall cycles; bus_err=1; pix_written unchanged; clr_stats then clears bus_err.
- nreset low mid-WRITE → avm_write=0 and counters=0 after that edge; the next tie grants line first.

Source files
------------

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter between the line and arc rasterizers, feeding a single-beat
// Avalon-MM frame-buffer write master with clipping, timeout and statistics.
module pixel_write_arbiter #(
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int FB_BASE   = 0,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              line_valid,
    input  logic [X_W-1:0]    line_x,
    input  logic [Y_W-1:0]    line_y,
    input  logic [23:0]       line_color,
    output logic              line_ready,
    input  logic              arc_valid,
    input  logic [X_W-1:0]    arc_x,
    input  logic [Y_W-1:0]    arc_y,
    input  logic [23:0]       arc_color,
    output logic              arc_ready,
    output logic              avm_write,
    output logic [ADDR_W-1:0] avm_address,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic              clr_stats,
    output logic              busy,
    output logic              bus_err,
    output logic [CNT_W-1:0]  pix_written,
    output logic [CNT_W-1:0]  pix_clipped
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WRITE} state_t;
    typedef enum logic {GRANT_LINE, GRANT_ARC} grant_t;

    state_t              state_q, state_d;
    grant_t              last_grant_q, last_grant_d;
    logic                avm_write_q, avm_write_d;
    logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
    logic [31:0]         avm_writedata_q, avm_writedata_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                bus_err_q, bus_err_d;
    logic [CNT_W-1:0]    pix_written_q, pix_written_d;
    logic [CNT_W-1:0]    pix_clipped_q, pix_clipped_d;

    logic                pick_arc;
    logic                pick_line;
    logic                take;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [23:0]         sel_color;
    logic                sel_clipped;
    logic [ADDR_W-1:0]   sel_addr;

    // On a tie the engine that did not win last time gets the bus.
    assign pick_arc  = arc_valid && (!line_valid || last_grant_q == GRANT_LINE);
    assign pick_line = line_valid && !pick_arc;

    assign line_ready = (state_q == IDLE) && pick_line;
    assign arc_ready  = (state_q == IDLE) && pick_arc;
    assign take       = line_ready || arc_ready;

    assign sel_x     = pick_arc ? arc_x     : line_x;
    assign sel_y     = pick_arc ? arc_y     : line_y;
    assign sel_color = pick_arc ? arc_color : line_color;

    assign sel_clipped = (32'(sel_x) >= 32'(FB_WIDTH)) || (32'(sel_y) >= 32'(FB_HEIGHT));

    // Arithmetic is done at ADDR_W so the byte address wraps modulo 2^ADDR_W.
    assign sel_addr = ADDR_W'(FB_BASE)
                    + ((ADDR_W'(sel_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(sel_x)) << 2);

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        avm_write_d     = avm_write_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        wait_cnt_d      = wait_cnt_q;
        bus_err_d       = bus_err_q;
        pix_written_d   = pix_written_q;
        pix_clipped_d   = pix_clipped_q;

        case (state_q)
            IDLE: begin
                if (take) begin
                    last_grant_d = pick_arc ? GRANT_ARC : GRANT_LINE;
                    if (sel_clipped) begin
                        if (pix_clipped_q != '1) begin
                            pix_clipped_d = pix_clipped_q + 1'b1;
                        end
                    end else begin
                        state_d         = WRITE;
                        avm_write_d     = 1'b1;
                        avm_address_d   = sel_addr;
                        avm_writedata_d = {8'h00, sel_color};
                        wait_cnt_d      = '0;
                    end
                end
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    state_d     = IDLE;
                    avm_write_d = 1'b0;
                    if (pix_written_q != '1) begin
                        pix_written_d = pix_written_q + 1'b1;
                    end
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th stalled cycle: give up on the slave.
                    state_d     = IDLE;
                    avm_write_d = 1'b0;
                    bus_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                avm_write_d = 1'b0;
            end
        endcase

        if (clr_stats) begin
            pix_written_d = '0;
            pix_clipped_d = '0;
            bus_err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q         <= IDLE;
            last_grant_q    <= GRANT_ARC;
            avm_write_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            wait_cnt_q      <= '0;
            bus_err_q       <= 1'b0;
            pix_written_q   <= '0;
            pix_clipped_q   <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            avm_write_q     <= avm_write_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            wait_cnt_q      <= wait_cnt_d;
            bus_err_q       <= bus_err_d;
            pix_written_q   <= pix_written_d;
            pix_clipped_q   <= pix_clipped_d;
        end
    end

    assign avm_write     = avm_write_q;
    assign avm_address   = avm_address_q;
    assign avm_writedata = avm_writedata_q;
    assign busy          = (state_q == WRITE);
    assign bus_err       = bus_err_q;
    assign pix_written   = pix_written_q;
    assign pix_clipped   = pix_clipped_q;

endmodule
